// File: rtl/weight_mac_29.sv
// rtl/weight_mac_29.sv - 36-lane signed dot product with registered adder tree and cross-chunk accumulator
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module weight_mac_29 #(
    parameter int ACC_W  = 2*`DATA_LEN+8,
    parameter int N_LANE = 36
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        first,
    input  logic                        last,
    input  logic                        x_valid,
    input  logic [N_LANE*`DATA_LEN-1:0] x_in,
    input  logic                        w_valid,
    input  logic [N_LANE*`DATA_LEN-1:0] w_q,
    output logic                        load,
    output logic                        busy,
    output logic                        chunk_done,
    output logic                        out_valid,
    output logic [ACC_W-1:0]            acc_out
);

    localparam int DL     = `DATA_LEN;
    localparam int PW     = 2*DL;
    localparam int N_GRP  = 6;
    localparam int GRP_SZ = N_LANE / N_GRP;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_MUL,
        S_SUM,
        S_ACC
    } state_t;

    state_t                  state_q, state_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic                    load_q, load_d;
    logic                    armed_q, armed_d;
    logic                    pend_q, pend_d;
    logic                    chunk_done_q, chunk_done_d;
    logic                    out_valid_q, out_valid_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ACC_W-1:0]        acc_out_q, acc_out_d;
    logic [N_LANE*DL-1:0]    w_r_q, w_r_d;
    logic [N_LANE*DL-1:0]    x_r_q, x_r_d;
    logic [PW-1:0]           prod_q [N_LANE];
    logic [PW-1:0]           prod_d [N_LANE];
    logic [ACC_W-1:0]        psum_q [N_GRP];
    logic [ACC_W-1:0]        psum_d [N_GRP];
    logic [ACC_W-1:0]        chunk_sum;

    function automatic logic [PW-1:0] mul_lane(input logic [DL-1:0] a, input logic [DL-1:0] b);
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        ax = {{DL{a[DL-1]}}, a};
        bx = {{DL{b[DL-1]}}, b};
        return ax * bx;
    endfunction

    function automatic logic [ACC_W-1:0] sext_prod(input logic [PW-1:0] p);
        return {{(ACC_W-PW){p[PW-1]}}, p};
    endfunction

    always_comb begin
        state_d      = state_q;
        first_d      = first_q;
        last_d       = last_q;
        load_d       = load_q;
        armed_d      = armed_q;
        pend_d       = 1'b0;
        chunk_done_d = 1'b0;
        out_valid_d  = 1'b0;
        acc_d        = acc_q;
        acc_out_d    = acc_out_q;
        w_r_d        = w_r_q;
        x_r_d        = x_r_q;
        prod_d       = prod_q;
        psum_d       = psum_q;
        chunk_sum    = '0;

        // Result presentation trails the accumulate by one cycle so acc_q is already final.
        if (pend_q) begin
            out_valid_d = 1'b1;
            acc_out_d   = acc_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    first_d = first;
                    last_d  = last;
                    load_d  = 1'b1;
                    armed_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // The weight store leaves valid high from the previous load; only trust it after a low cycle.
                if (!w_valid) begin
                    armed_d = 1'b1;
                end
                if (armed_q && w_valid && x_valid) begin
                    w_r_d   = w_q;
                    x_r_d   = x_in;
                    load_d  = 1'b0;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                for (int i = 0; i < N_LANE; i++) begin
                    prod_d[i] = mul_lane(w_r_q[i*DL +: DL], x_r_q[i*DL +: DL]);
                end
                state_d = S_SUM;
            end
            S_SUM: begin
                for (int g = 0; g < N_GRP; g++) begin
                    psum_d[g] = '0;
                    for (int j = 0; j < GRP_SZ; j++) begin
                        psum_d[g] = psum_d[g] + sext_prod(prod_q[g*GRP_SZ + j]);
                    end
                end
                state_d = S_ACC;
            end
            S_ACC: begin
                for (int g = 0; g < N_GRP; g++) begin
                    chunk_sum = chunk_sum + psum_q[g];
                end
                acc_d        = (first_q ? '0 : acc_q) + chunk_sum;
                chunk_done_d = 1'b1;
                pend_d       = last_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            first_q      <= 1'b0;
            last_q       <= 1'b0;
            load_q       <= 1'b0;
            armed_q      <= 1'b0;
            pend_q       <= 1'b0;
            chunk_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            acc_q        <= '0;
            acc_out_q    <= '0;
            w_r_q        <= '0;
            x_r_q        <= '0;
            for (int i = 0; i < N_LANE; i++) begin
                prod_q[i] <= '0;
            end
            for (int g = 0; g < N_GRP; g++) begin
                psum_q[g] <= '0;
            end
        end else begin
            state_q      <= state_d;
            first_q      <= first_d;
            last_q       <= last_d;
            load_q       <= load_d;
            armed_q      <= armed_d;
            pend_q       <= pend_d;
            chunk_done_q <= chunk_done_d;
            out_valid_q  <= out_valid_d;
            acc_q        <= acc_d;
            acc_out_q    <= acc_out_d;
            w_r_q        <= w_r_d;
            x_r_q        <= x_r_d;
            prod_q       <= prod_d;
            psum_q       <= psum_d;
        end
    end

    assign load       = load_q;
    assign busy       = (state_q != S_IDLE);
    assign chunk_done = chunk_done_q;
    assign out_valid  = out_valid_q;
    assign acc_out    = acc_out_q;

endmodule

// File: tb/tb_weight_mac_29.sv
// tb/tb_weight_mac_29.sv - scoreboard bench for weight_mac_29
`timescale 1ns/1ps
`ifndef DATA_LEN
`define DATA_LEN 8
`endif

module tb_weight_mac_29;

    localparam int DL    = `DATA_LEN;
    localparam int NL    = 36;
    localparam int ACC_W = 2*DL+8;
    localparam int VW    = NL*DL;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, first, last, x_valid, w_valid;
    logic [VW-1:0]    x_in, w_q;
    logic             load, busy, chunk_done, out_valid;
    logic [ACC_W-1:0] acc_out;

    weight_mac_29 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first      (first),
        .last       (last),
        .x_valid    (x_valid),
        .x_in       (x_in),
        .w_valid    (w_valid),
        .w_q        (w_q),
        .load       (load),
        .busy       (busy),
        .chunk_done (chunk_done),
        .out_valid  (out_valid),
        .acc_out    (acc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ACC_W-1:0] val;
        int               when;
    } exp_t;

    int               checks   = 0;
    int               failures = 0;
    int               cyc      = 0;
    int               cd_count = 0;
    int               ov_count = 0;
    logic [ACC_W-1:0] model_acc = '0;
    exp_t             sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (chunk_done === 1'b1) cd_count++;
        if (out_valid === 1'b1) begin
            ov_count++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected_out acc_out=%0d required=no output", $signed(acc_out));
            end else begin
                e = sb.pop_front();
                if (acc_out !== e.val || cyc != e.when) begin
                    failures++;
                    $display("FAIL sb_result acc_out=%0d at cycle %0d required=%0d at cycle %0d",
                             $signed(acc_out), cyc, $signed(e.val), e.when);
                end
            end
        end
    end

    function automatic logic [VW-1:0] fill(input int v);
        logic [VW-1:0] r;
        logic [DL-1:0] b;
        b = v[DL-1:0];
        for (int i = 0; i < NL; i++) r[i*DL +: DL] = b;
        return r;
    endfunction

    function automatic logic [ACC_W-1:0] dot(input logic [VW-1:0] w, input logic [VW-1:0] x);
        longint s;
        longint a;
        longint b;
        s = 0;
        for (int i = 0; i < NL; i++) begin
            a = $signed(w[i*DL +: DL]);
            b = $signed(x[i*DL +: DL]);
            s = s + a * b;
        end
        return s[ACC_W-1:0];
    endfunction

    task automatic do_fetch(input logic f, input logic l, input logic [VW-1:0] w, input logic [VW-1:0] x,
                            input int w_rise, input int x_rise, input bit stale,
                            output bit ok, output int acc_cyc);
        int  exp_k;
        int  k;
        bit  done;
        exp_k   = (w_rise > x_rise) ? w_rise : x_rise;
        ok      = 1'b0;
        acc_cyc = 0;
        done    = 1'b0;
        k       = 0;
        @(negedge clk);
        start   = 1'b1;
        first   = f;
        last    = l;
        x_in    = x;
        x_valid = 1'b0;
        w_q     = stale ? ~w : w;
        w_valid = stale;
        @(negedge clk);
        start = 1'b0;
        while (!done && k < 40) begin
            w_valid = (stale && k == 0) ? 1'b1 : (k >= w_rise);
            w_q     = (k >= w_rise) ? w : ~w;
            x_valid = (k >= x_rise);
            @(negedge clk);
            if (load !== 1'b1) begin
                done = 1'b1;
                checks++;
                if (k != exp_k || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL fetch_accept accepted after cycle %0d busy=%b required cycle %0d busy=1",
                             k, busy, exp_k);
                end else begin
                    ok = 1'b1;
                end
                acc_cyc = cyc;
            end
            k++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL fetch_timeout load=%b still waiting after %0d cycles required accept after cycle %0d",
                     load, k, exp_k);
        end
        w_valid = 1'b0;
        x_valid = 1'b0;
    endtask

    task automatic run_chunk(input logic f, input logic l, input logic [VW-1:0] w, input logic [VW-1:0] x,
                             input int w_rise, input int x_rise, input bit stale, input bit poke_sum);
        bit ok;
        int a;
        do_fetch(f, l, w, x, w_rise, x_rise, stale, ok, a);
        if (ok) begin
            model_acc = (f ? '0 : model_acc) + dot(w, x);
            if (l) sb.push_back('{val: model_acc, when: a + 4});
            @(negedge clk);
            if (poke_sum) begin
                start = 1'b1;
                first = 1'b1;
                last  = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            checks++;
            if (chunk_done !== 1'b1 || busy !== 1'b0 || load !== 1'b0) begin
                failures++;
                $display("FAIL chunk_done_latency chunk_done=%b busy=%b load=%b required 1 0 0 at accept+3",
                         chunk_done, busy, load);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({load, busy, chunk_done, out_valid} !== 4'b0 || acc_out !== '0) begin
            failures++;
            $display("FAIL reset_values load=%b busy=%b cd=%b ov=%b acc_out=%0d required all 0",
                     load, busy, chunk_done, out_valid, acc_out);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_chunk;
        int ov0;
        ov0 = ov_count;
        run_chunk(1'b1, 1'b1, fill(1), fill(2), 1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(72) || ov_count - ov0 != 1) begin
            failures++;
            $display("FAIL single_chunk acc_out=%0d outputs=%0d required 72 and 1", acc_out, ov_count - ov0);
        end
    endtask

    task automatic test_stale_valid;
        run_chunk(1'b1, 1'b1, fill(3), fill(-1), 6, 0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(-108)) begin
            failures++;
            $display("FAIL stale_valid acc_out=%0d required -108", $signed(acc_out));
        end
    endtask

    task automatic test_multi_phase;
        int cd0, ov0;
        cd0 = cd_count;
        ov0 = ov_count;
        for (int k = 0; k < 8; k++) begin
            run_chunk(k == 0, k == 7, fill(k + 1), fill(1), 1, 0, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(1296) || cd_count - cd0 != 8 || ov_count - ov0 != 1) begin
            failures++;
            $display("FAIL multi_phase acc_out=%0d chunk_done=%0d out_valid=%0d required 1296 8 1",
                     acc_out, cd_count - cd0, ov_count - ov0);
        end
    endtask

    task automatic test_signed;
        logic [VW-1:0] w, x;
        w = '0;
        x = '0;
        w[DL-1:0] = DL'(-3);
        x[DL-1:0] = DL'(5);
        run_chunk(1'b1, 1'b1, w, x, 1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(-15)) begin
            failures++;
            $display("FAIL signed_lane0 acc_out=%0d required -15", $signed(acc_out));
        end
        run_chunk(1'b0, 1'b1, w, x, 1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(-30)) begin
            failures++;
            $display("FAIL acc_kept_after_out acc_out=%0d required -30", $signed(acc_out));
        end
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 16; k++) begin
            run_chunk(k == 0, k == 15, fill(-128), fill(127), 1, 0, 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(7413760)) begin
            failures++;
            $display("FAIL wrap acc_out=%0d required 7413760", acc_out);
        end
    endtask

    task automatic test_handshake;
        run_chunk(1'b1, 1'b1, fill(2), fill(5), 1, 11, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || load !== 1'b0 || acc_out !== ACC_W'(360)) begin
            failures++;
            $display("FAIL handshake busy=%b load=%b acc_out=%0d required 0 0 360", busy, load, acc_out);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int a, cd0, ov0;
        do_fetch(1'b1, 1'b1, fill(4), fill(4), 1, 0, 1'b0, ok, a);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({load, busy, chunk_done, out_valid} !== 4'b0 || acc_out !== '0) begin
            failures++;
            $display("FAIL reset_mid_mul load=%b busy=%b cd=%b ov=%b acc_out=%0d required all 0",
                     load, busy, chunk_done, out_valid, acc_out);
        end
        @(negedge clk);
        rst = 1'b0;
        model_acc = '0;
        cd0 = cd_count;
        ov0 = ov_count;
        repeat (8) @(negedge clk);
        checks++;
        if (cd_count != cd0 || ov_count != ov0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_discard chunk_done=%0d out_valid=%0d busy=%b required 0 0 0",
                     cd_count - cd0, ov_count - ov0, busy);
        end
        start = 1'b1;
        first = 1'b1;
        last  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (load !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fetch load=%b busy=%b required 0 0", load, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        run_chunk(1'b0, 1'b1, fill(1), fill(1), 1, 0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (acc_out !== ACC_W'(36)) begin
            failures++;
            $display("FAIL acc_cleared_by_reset acc_out=%0d required 36", acc_out);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        first   = 1'b0;
        last    = 1'b0;
        x_valid = 1'b0;
        w_valid = 1'b0;
        x_in    = '0;
        w_q     = '0;
        test_reset();
        test_single_chunk();
        test_stale_valid();
        test_multi_phase();
        test_signed();
        test_wrap();
        test_handshake();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_leftover pending=%0d required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/weight_mac_29.md
Name: weight_mac_29

Overview:
- Dot-product/accumulate stage directly downstream of weight_store_29.
- Per chunk: drives weight_store_29's load, waits for its 36-weight vector, and pairs it with a 36-element activation vector from the feature buffer.
- Multiplies the pairs, reduces them through a registered adder tree, and accumulates across phases (chunks).
- Emits one accumulated result per output neuron/channel to the activation/requant stage.

Parameters:
- ACC_W, 2*`data_len+8, accumulator and result width (signed).
- N_LANE, 36, lanes per chunk; fixed to match weight_store_29 output; other values unsupported.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one chunk; honoured only in IDLE.
- first  in  1  sampled with start; 1 = clear accumulator before adding this chunk.
- last  in  1  sampled with start; 1 = present result after this chunk.
- x_valid  in  1  activation vector present and stable on x_in.
- x_in  in  36*`data_len  activations, lane i at bits [i*`data_len +: `data_len], signed.
- w_valid  in  1  valid from weight_store_29.
- w_q  in  36*`data_len  q from weight_store_29, same lane packing, signed.
- load  out  1  load to weight_store_29.
- busy  out  1  high in any state except IDLE.
- chunk_done  out  1  one-cycle pulse when a chunk has been added to the accumulator.
- out_valid  out  1  one-cycle pulse; acc_out valid.
- acc_out  out  ACC_W  accumulated dot product, signed; held until next out_valid.

Behaviour:
- Reset values (async, immediate): state=IDLE, load=0, busy=0, chunk_done=0, out_valid=0, acc_out=0, accumulator=0, armed=0, all pipeline registers=0.
- States: IDLE, FETCH, MUL, SUM, ACC.
- IDLE -> FETCH on start.
  - Latch first and last.
  - load<=1, armed<=0.
- FETCH (load=1):
  - Stale-valid guard: weight_store_29 keeps valid high between loads and clears it only one cycle after load rises. Therefore armed<=1 on any FETCH cycle with w_valid=0.
  - Accept when armed && w_valid && x_valid:
    - Register w_q and x_in.
    - load<=0.
    - Go to MUL.
  - No timeout; FETCH waits indefinitely. x_valid may rise before or after w_valid.
- MUL: register 36 signed products, each 2*`data_len bits; go to SUM.
- SUM: register 6 partial sums, each the sum of 6 consecutive lanes, sign-extended to ACC_W; go to ACC.
- ACC:
  - new = (first_l ? 0 : acc) + sum of 6 partials; acc<=new.
  - chunk_done=1 for this one cycle.
  - If last_l: acc_out<=new and out_valid=1 the following cycle.
  - Go to IDLE.
- Latency: accept edge -> chunk_done at +3 cycles; out_valid/acc_out at +4.
- Minimum start-to-start spacing: FETCH + 3 cycles. start is accepted again on the cycle state returns to IDLE.
- Arithmetic: two's complement throughout. Overflow beyond ACC_W wraps (low ACC_W bits kept); no saturation.
- Boundary cases:
  - start while busy: ignored, no side effects.
  - first=1 with last=1: single-chunk result.
  - Accumulator is not cleared after out_valid; only first clears it.
  - Reset mid-FETCH: load drops asynchronously; weight_store_29 reinitialises on its next load.
  - Reset in MUL/SUM/ACC: partial chunk discarded; no chunk_done or out_valid.
- cs/phase to weight_store_29 are driven by the controller and must be stable from start until chunk_done. This block does not check them.

Test Plan:
- Reset: rst pulse mid-MUL -> all outputs 0 immediately; state IDLE; no chunk_done or out_valid afterwards.
- Single chunk: first=last=1, all w=1, all x=2 -> out_valid exactly 4 cycles after accept, acc_out=72.
- Stale valid: w_valid held 1 when start arrives, then low 1 cycle, then high 5 cycles later -> accept only on the later rise; load high throughout the wait.
- Multi-phase: 8 chunks, first on chunk 0 and last on chunk 7; chunk k uses w=k+1, x=1 on all lanes -> acc_out=36*36=1296; out_valid once; chunk_done 8 times.
- Signed/wrap: lane 0 w=-3, x=5, other lanes 0 -> acc_out=-15. Max-negative products on all 36 lanes over enough chunks -> result wraps modulo 2^ACC_W.
- Handshake ordering: x_valid arrives 10 cycles after w_valid -> accept on x_valid cycle. start pulsed during SUM -> ignored.
